load_formatter: RTL and testbench
=================================

# load_formatter

Parametrised, pipelined load-data formatter for the MEM/WB path of the MIPS core. Accepts the raw memory word for a load, selects the addressed byte lane(s), sign- or zero-extends to the register width and flags misaligned accesses. A valid/ready handshake with a two-entry skid buffer gives one result per cycle under back-pressure without combinational ready paths.

## Interface
- `NB_DATA`, 32, data/register width in bits; 32 or 64.
- `NB_MASK`, 2, access-size code width.
- `NB_OFFSET`, log2(NB_DATA/8), byte-offset width.
- `NB_TAG`, 5, destination-register tag carried alongside the data.
- `i_clock`  in  1  clock, rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  input transfer valid.
- `o_ready`  out  1  block can accept an input this cycle.
- `i_dato`  in  NB_DATA  raw memory word, little-endian lanes.
- `i_offset`  in  NB_OFFSET  low address bits of the load.
- `i_mascara`  in  NB_MASK  size code: 00 byte, 01 half, 10 word, 11 double.
- `i_is_unsigned`  in  1  1 = zero-extend (LBU/LHU/LWU).
- `i_tag`  in  NB_TAG  destination register.
- `o_valid`  out  1  output transfer valid.
- `i_ready`  in  1  downstream accepts output.
- `o_dato`  out  NB_DATA  formatted load data.
- `o_tag`  out  NB_TAG  tag of `o_dato`.
- `o_misaligned`  out  1  address-error flag for this result.

## Operation
- Size in bytes S = 2^`i_mascara`. Code 11 with NB_DATA=32 is illegal: treated as word (S=4).
- Misaligned when `i_offset` mod S != 0. Result then: `o_dato`=0, `o_misaligned`=1, tag passed through.
- Aligned: field = `i_dato` bits [8·offset + 8·S − 1 : 8·offset]. If S·8 < NB_DATA and `i_is_unsigned`=0, upper bits replicate field MSB; otherwise zero-filled. S·8 = NB_DATA passes `i_dato` unchanged (`i_is_unsigned` ignored).
- Formatting is combinational on the input side; result, tag and flag are captured together as one entry.
- Buffer states: EMPTY (0 entries), ONE (output reg valid), FULL (output reg + skid reg valid).
  - EMPTY: input accepted -> ONE.
  - ONE: accept & !drain -> FULL (entry to skid); accept & drain -> ONE (new entry to output reg); drain only -> EMPTY.
  - FULL: `o_ready`=0; drain -> ONE, skid entry moves to output reg.
- Transfer in = `i_valid` & `o_ready`; transfer out = `o_valid` & `i_ready`.
- Order strictly preserved; no entry dropped or duplicated.

## Timing
- Reset (asynchronous assert, synchronous release): state EMPTY, `o_valid`=0, `o_ready`=1, `o_dato`=0, `o_tag`=0, `o_misaligned`=0, skid reg cleared.
- Latency: input accepted on edge N -> `o_valid`=1 with its data after edge N.
- `o_ready` driven from state register only (no `i_ready`-to-`o_ready` combinational path); `o_ready` = (state != FULL).
- `o_dato`/`o_tag`/`o_misaligned` held stable while `o_valid`=1 and `i_ready`=0.
- Simultaneous accept and drain in ONE: full throughput, 1 result/cycle.
- Reset mid-transfer discards all buffered entries; first post-reset output is a post-reset input.

## Structure
- Shared package `mem_pkg`: size codes (`SIZE_BYTE`..`SIZE_DOUBLE`), buffer state encoding, `NB_TAG` default.
- Sub-module `load_extend`: combinational lane select + extension + misalign detect, instanced once on the input side; buffer FSM and registers in the top.

## Test plan
- Signed byte: `i_dato`=0x1234_80FF, offset 1, mask 00, unsigned 0 -> `o_dato`=0xFFFF_FF80, `o_misaligned`=0, one cycle later.
- Unsigned half: same data, offset 2, mask 01, unsigned 1 -> 0x0000_1234; signed -> 0x0000_1234 (MSB 0).
- Misaligned: offset 1, mask 01 -> `o_dato`=0, `o_misaligned`=1, tag preserved; offset 2, mask 10 also misaligned.
- Back-pressure: 4 back-to-back inputs with `i_ready`=0 -> accepts 2, `o_ready`=0 after second; release `i_ready` -> outputs in order, 1/cycle, then remaining 2 accepted.
- NB_DATA=64: `i_dato`=0x8000_0000_0000_0000, offset 4, mask 10 signed -> 0xFFFF_FFFF_8000_0000; mask 11 offset 0 -> passthrough.
- Reset asserted while FULL -> `o_valid`=0 and `o_ready`=1 immediately (asynchronous), no stale output after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load path: access-size codes, skid-buffer
// state encoding and the default destination-tag width.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int NB_TAG_DEF = 5;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatting: picks the addressed byte lane(s), sign- or
// zero-extends to the register width and flags misaligned accesses.
module load_extend
    import mem_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_MASK   = 2,
    parameter int NB_OFFSET = $clog2(NB_DATA / 8)
) (
    input  logic [NB_DATA-1:0]   i_dato,
    input  logic [NB_OFFSET-1:0] i_offset,
    input  logic [NB_MASK-1:0]   i_mascara,
    input  logic                 i_is_unsigned,
    output logic [NB_DATA-1:0]   o_dato,
    output logic                 o_misaligned
);

    logic [1:0]           w_code;
    logic [NB_OFFSET-1:0] w_lane_mask;
    logic [NB_DATA-1:0]   w_shift;
    logic [NB_DATA-1:0]   w_fmt;

    // A double-word load on a 32-bit datapath degrades to a word load.
    assign w_code = ((NB_DATA == 32) && (i_mascara[1:0] == SIZE_DOUBLE)) ?
                    SIZE_WORD : i_mascara[1:0];

    assign w_lane_mask  = NB_OFFSET'((32'd1 << w_code) - 32'd1);
    assign o_misaligned = |(i_offset & w_lane_mask);
    assign w_shift      = i_dato >> {i_offset, 3'b000};

    always_comb begin
        w_fmt = i_dato;
        case (w_code)
            SIZE_BYTE: w_fmt = i_is_unsigned ? NB_DATA'(w_shift[7:0])
                                             : NB_DATA'($signed(w_shift[7:0]));
            SIZE_HALF: w_fmt = i_is_unsigned ? NB_DATA'(w_shift[15:0])
                                             : NB_DATA'($signed(w_shift[15:0]));
            SIZE_WORD: w_fmt = i_is_unsigned ? NB_DATA'(w_shift[31:0])
                                             : NB_DATA'($signed(w_shift[31:0]));
            default:   w_fmt = i_dato;
        endcase
    end

    assign o_dato = o_misaligned ? '0 : w_fmt;

endmodule

// File: rtl/load_formatter.sv
// Pipelined load-data formatter: formats on the input side, then buffers
// results in an output register plus one skid register.
module load_formatter
    import mem_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_MASK   = 2,
    parameter int NB_OFFSET = $clog2(NB_DATA / 8),
    parameter int NB_TAG    = NB_TAG_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_DATA-1:0]   i_dato,
    input  logic [NB_OFFSET-1:0] i_offset,
    input  logic [NB_MASK-1:0]   i_mascara,
    input  logic                 i_is_unsigned,
    input  logic [NB_TAG-1:0]    i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NB_DATA-1:0]   o_dato,
    output logic [NB_TAG-1:0]    o_tag,
    output logic                 o_misaligned,
    output logic [1:0]           o_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; o_ready depends only on the buffer state register.
    logic [1:0]         r_state;
    logic [NB_DATA-1:0] r_out_dato, r_skid_dato;
    logic [NB_TAG-1:0]  r_out_tag, r_skid_tag;
    logic               r_out_mis, r_skid_mis;

    logic [NB_DATA-1:0] w_dato;
    logic               w_mis;
    logic               w_in;
    logic               w_out;

    load_extend #(
        .NB_DATA   (NB_DATA),
        .NB_MASK   (NB_MASK),
        .NB_OFFSET (NB_OFFSET)
    ) u_load_extend (
        .i_dato        (i_dato),
        .i_offset      (i_offset),
        .i_mascara     (i_mascara),
        .i_is_unsigned (i_is_unsigned),
        .o_dato        (w_dato),
        .o_misaligned  (w_mis)
    );

    assign o_ready = (r_state != ST_FULL);
    assign o_valid = (r_state != ST_EMPTY);
    assign w_in    = i_valid & o_ready;
    assign w_out   = o_valid & i_ready;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_EMPTY;
            r_out_dato  <= '0;
            r_out_tag   <= '0;
            r_out_mis   <= 1'b0;
            r_skid_dato <= '0;
            r_skid_tag  <= '0;
            r_skid_mis  <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in) begin
                        r_out_dato <= w_dato;
                        r_out_tag  <= i_tag;
                        r_out_mis  <= w_mis;
                        r_state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in && w_out) begin
                        r_out_dato <= w_dato;
                        r_out_tag  <= i_tag;
                        r_out_mis  <= w_mis;
                    end else if (w_in) begin
                        r_skid_dato <= w_dato;
                        r_skid_tag  <= i_tag;
                        r_skid_mis  <= w_mis;
                        r_state     <= ST_FULL;
                    end else if (w_out) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out) begin
                        r_out_dato <= r_skid_dato;
                        r_out_tag  <= r_skid_tag;
                        r_out_mis  <= r_skid_mis;
                        r_state    <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign o_dato       = r_out_dato;
    assign o_tag        = r_out_tag;
    assign o_misaligned = r_out_mis;
    assign o_state      = r_state;

endmodule

// File: tb/tb_load_formatter.sv
// Bench for load_formatter: formatting vectors on 32- and 64-bit instances,
// then back-pressure, throughput and reset-while-full sequences.
module tb_load_formatter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        v32 = 1'b0, ir32 = 1'b1, u32 = 1'b0;
    logic        rdy32, ov32, om32;
    logic [31:0] d32 = '0, od32;
    logic [1:0]  off32 = '0, m32 = '0, st32;
    logic [4:0]  tag32 = '0, ot32;

    // 64-bit instance
    logic        v64 = 1'b0, ir64 = 1'b1, u64 = 1'b0;
    logic        rdy64, ov64, om64;
    logic [63:0] d64 = '0, od64;
    logic [2:0]  off64 = '0;
    logic [1:0]  m64 = '0, st64;
    logic [4:0]  tag64 = '0, ot64;

    load_formatter #(.NB_DATA(32)) dut32 (
        .i_clock(clk), .i_reset(rst_n), .i_valid(v32), .o_ready(rdy32),
        .i_dato(d32), .i_offset(off32), .i_mascara(m32), .i_is_unsigned(u32),
        .i_tag(tag32), .o_valid(ov32), .i_ready(ir32), .o_dato(od32),
        .o_tag(ot32), .o_misaligned(om32), .o_state(st32)
    );

    load_formatter #(.NB_DATA(64)) dut64 (
        .i_clock(clk), .i_reset(rst_n), .i_valid(v64), .o_ready(rdy64),
        .i_dato(d64), .i_offset(off64), .i_mascara(m64), .i_is_unsigned(u64),
        .i_tag(tag64), .o_valid(ov64), .i_ready(ir64), .o_dato(od64),
        .o_tag(ot64), .o_misaligned(om64), .o_state(st64)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_pop = 0;
    logic sb_en = 1'b0;
    logic [37:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: outputs that transfer on the next rising edge are popped here.
    always @(negedge clk) begin
        if (rst_n && sb_en && ov32 && ir32) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", {26'd0, od32, ot32, om32}, 64'h0);
            end else begin
                check("sb_out", {26'd0, od32, ot32, om32}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [31:0] dato;
        logic [1:0]  off;
        logic [1:0]  m;
        logic        u;
        logic [4:0]  tag;
        logic [31:0] exp;
        logic        mis;
    } vec32_t;

    typedef struct {
        logic [63:0] dato;
        logic [2:0]  off;
        logic [1:0]  m;
        logic        u;
        logic [4:0]  tag;
        logic [63:0] exp;
        logic        mis;
    } vec64_t;

    vec32_t tab32[12];
    vec64_t tab64[5];

    task automatic apply32(input vec32_t t);
        v32 = 1'b1; d32 = t.dato; off32 = t.off; m32 = t.m; u32 = t.u; tag32 = t.tag;
        ir32 = 1'b1;
        check("t32_ready_before", {63'd0, rdy32}, 64'd1);
        @(posedge clk); #1;
        v32 = 1'b0;
        check("t32_valid", {63'd0, ov32}, 64'd1);
        check("t32_dato", {32'd0, od32}, {32'd0, t.exp});
        check("t32_tag_mis", {57'd0, ot32, om32}, {57'd0, t.tag, t.mis});
        @(posedge clk); #1;
    endtask

    task automatic apply64(input vec64_t t);
        v64 = 1'b1; d64 = t.dato; off64 = t.off; m64 = t.m; u64 = t.u; tag64 = t.tag;
        @(posedge clk); #1;
        v64 = 1'b0;
        check("t64_valid", {63'd0, ov64}, 64'd1);
        check("t64_dato", od64, t.exp);
        check("t64_tag_mis", {57'd0, ot64, om64}, {57'd0, t.tag, t.mis});
        @(posedge clk); #1;
    endtask

    // Hold an input valid until it is taken; returns one step after the accepting edge.
    task automatic send32(input logic [31:0] dato, input logic [1:0] off, input logic [1:0] m,
                          input logic u, input logic [4:0] tag);
        logic acc;
        acc = 1'b0;
        v32 = 1'b1; d32 = dato; off32 = off; m32 = m; u32 = u; tag32 = tag;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = rdy32;
            @(posedge clk); #1;
        end
        v32 = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        tab32[0]  = '{32'h1234_80FF, 2'd1, 2'b00, 1'b0, 5'd1,  32'hFFFF_FF80, 1'b0};
        tab32[1]  = '{32'h1234_80FF, 2'd2, 2'b01, 1'b1, 5'd2,  32'h0000_1234, 1'b0};
        tab32[2]  = '{32'h1234_80FF, 2'd2, 2'b01, 1'b0, 5'd3,  32'h0000_1234, 1'b0};
        tab32[3]  = '{32'h1234_80FF, 2'd1, 2'b01, 1'b0, 5'd7,  32'h0000_0000, 1'b1};
        tab32[4]  = '{32'h1234_80FF, 2'd2, 2'b10, 1'b0, 5'd9,  32'h0000_0000, 1'b1};
        tab32[5]  = '{32'h1234_80FF, 2'd0, 2'b10, 1'b0, 5'd10, 32'h1234_80FF, 1'b0};
        tab32[6]  = '{32'h1234_80FF, 2'd0, 2'b00, 1'b1, 5'd11, 32'h0000_00FF, 1'b0};
        tab32[7]  = '{32'h1234_80FF, 2'd0, 2'b00, 1'b0, 5'd12, 32'hFFFF_FFFF, 1'b0};
        tab32[8]  = '{32'h1234_80FF, 2'd3, 2'b00, 1'b0, 5'd13, 32'h0000_0012, 1'b0};
        tab32[9]  = '{32'h1234_80FF, 2'd0, 2'b01, 1'b0, 5'd14, 32'hFFFF_80FF, 1'b0};
        tab32[10] = '{32'h1234_80FF, 2'd0, 2'b11, 1'b1, 5'd15, 32'h1234_80FF, 1'b0};
        tab32[11] = '{32'h1234_80FF, 2'd2, 2'b11, 1'b0, 5'd31, 32'h0000_0000, 1'b1};

        tab64[0] = '{64'h8000_0000_0000_0000, 3'd4, 2'b10, 1'b0, 5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tab64[1] = '{64'h8000_0000_0000_0000, 3'd0, 2'b11, 1'b0, 5'd5, 64'h8000_0000_0000_0000, 1'b0};
        tab64[2] = '{64'h8000_0000_0000_0000, 3'd4, 2'b10, 1'b1, 5'd6, 64'h0000_0000_8000_0000, 1'b0};
        tab64[3] = '{64'h8000_0000_0000_0000, 3'd4, 2'b11, 1'b0, 5'd8, 64'h0, 1'b1};
        tab64[4] = '{64'h0123_4567_89AB_CDEF, 3'd6, 2'b01, 1'b0, 5'd9, 64'h0000_0000_0000_0123, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, ov32}, 64'd0);
        check("rst_ready", {63'd0, rdy32}, 64'd1);
        check("rst_outs", {26'd0, od32, ot32, om32}, 64'd0);
        check("rst_state", {62'd0, st32}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tab32[i]) apply32(tab32[i]);
        foreach (tab64[i]) apply64(tab64[i]);

        // Back-pressure: two taken, then stall, then release at full rate.
        sb_en = 1'b1;
        n_pop = 0;
        ir32 = 1'b0;
        exp_q.push_back({32'h0000_00AA, 5'd1, 1'b0});
        exp_q.push_back({32'hFFFF_FFBB, 5'd2, 1'b0});
        exp_q.push_back({32'hFFFF_CCCC, 5'd3, 1'b0});
        exp_q.push_back({32'h0000_0000, 5'd4, 1'b1});
        send32(32'h0000_00AA, 2'd0, 2'b00, 1'b1, 5'd1);
        check("bp_ready_one", {63'd0, rdy32}, 64'd1);
        send32(32'h0000_BB00, 2'd1, 2'b00, 1'b0, 5'd2);
        check("bp_ready_full", {63'd0, rdy32}, 64'd0);
        check("bp_state_full", {62'd0, st32}, 64'd2);
        v32 = 1'b1; d32 = 32'hCCCC_0000; off32 = 2'd2; m32 = 2'b01; u32 = 1'b0; tag32 = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold_ready", {63'd0, rdy32}, 64'd0);
        check("bp_hold_out", {26'd0, od32, ot32, om32}, {26'd0, 32'h0000_00AA, 5'd1, 1'b0});
        ir32 = 1'b1;
        send32(32'hCCCC_0000, 2'd2, 2'b01, 1'b0, 5'd3);
        send32(32'h1234_5678, 2'd1, 2'b01, 1'b0, 5'd4);
        @(posedge clk); #1;
        check("bp_pop_count", 64'(n_pop), 64'd4);
        check("bp_drained", {63'd0, ov32}, 64'd0);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset while full discards both buffered entries.
        ir32 = 1'b0;
        send32(32'h0000_0011, 2'd0, 2'b00, 1'b1, 5'd20);
        send32(32'h0000_0022, 2'd0, 2'b00, 1'b1, 5'd21);
        check("rf_full", {62'd0, st32}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rf_async_valid", {63'd0, ov32}, 64'd0);
        check("rf_async_ready", {63'd0, rdy32}, 64'd1);
        check("rf_async_outs", {26'd0, od32, ot32, om32}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ir32 = 1'b1;
        n_pop = 0;
        exp_q.push_back({32'hFFFF_FF99, 5'd22, 1'b0});
        send32(32'h0000_9900, 2'd1, 2'b00, 1'b0, 5'd22);
        repeat (3) @(posedge clk);
        #1;
        check("rf_pop_count", 64'(n_pop), 64'd1);
        check("rf_queue_empty", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
